// File: rtl/mi2c_pkg.sv
// Shared definitions for the I2C master: engine command codes and the
// sequencer state encoding, plus the state-to-command mapping.
package mi2c_pkg;

    localparam logic [5:0] CMD_IDLE = 6'h00;
    localparam logic [5:0] CMD_STAR = 6'h01;
    localparam logic [5:0] CMD_WR   = 6'h02;
    localparam logic [5:0] CMD_GACK = 6'h04;
    localparam logic [5:0] CMD_RD   = 6'h08;
    localparam logic [5:0] CMD_OACK = 6'h10;
    localparam logic [5:0] CMD_STOP = 6'h20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DEV_W,
        ST_ACK_DW,
        ST_REG_H,
        ST_ACK_RH,
        ST_REG_L,
        ST_ACK_RL,
        ST_WDATA,
        ST_ACK_WD,
        ST_RSTART,
        ST_DEV_R,
        ST_ACK_DR,
        ST_RDATA,
        ST_MACK,
        ST_STOP
    } state_t;

    function automatic logic [5:0] state_cmd(input state_t st);
        case (st)
            ST_START, ST_RSTART:                                  return CMD_STAR;
            ST_DEV_W, ST_REG_H, ST_REG_L, ST_WDATA, ST_DEV_R:     return CMD_WR;
            ST_ACK_DW, ST_ACK_RH, ST_ACK_RL, ST_ACK_WD, ST_ACK_DR: return CMD_GACK;
            ST_RDATA:                                             return CMD_RD;
            ST_MACK:                                              return CMD_OACK;
            ST_STOP:                                              return CMD_STOP;
            default:                                              return CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mi2c_ctrl.sv
// Register-level transaction sequencer for the mi2c_drive bit engine.
// One state per engine command; the FSM advances only on cmd_done_i.
module mi2c_ctrl
    import mi2c_pkg::*;
#(
    parameter int REG_ADDR_BYTES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        req_rw_i,
    input  logic [6:0]  dev_addr_i,
    input  logic [15:0] reg_addr_i,
    input  logic [3:0]  len_i,
    input  logic [7:0]  wr_data_i,
    output logic        wr_data_rd_o,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cmd_en_o,
    output logic [5:0]  cmd_sta_o,
    output logic [7:0]  tx_data_o,
    output logic        rd_over_o,
    input  logic        slave_ack_i,
    input  logic        cmd_done_i,
    input  logic [7:0]  rd_data_i
);

    localparam bit TWO_BYTE = (REG_ADDR_BYTES == 2);

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [6:0]  dev_q, dev_d;
    logic [15:0] reg_q, reg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cmd_en_q, cmd_en_d;
    logic [5:0]  cmd_sta_q, cmd_sta_d;
    logic [7:0]  tx_q, tx_d;
    logic        rd_over_q, rd_over_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        wr_rd_q, wr_rd_d;
    logic        launch;

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        cmd_en_d   = 1'b0;
        cmd_sta_d  = cmd_sta_q;
        tx_d       = tx_q;
        rd_over_d  = rd_over_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_rd_d    = 1'b0;
        launch     = 1'b0;

        if (state_q == ST_IDLE) begin
            // done_q blocks a request on the completion cycle itself
            if (req_i && !done_q) begin
                rw_d    = req_rw_i;
                dev_d   = dev_addr_i;
                reg_d   = reg_addr_i;
                cnt_d   = len_i;
                err_d   = 1'b0;
                busy_d  = 1'b1;
                state_d = ST_START;
                launch  = 1'b1;
            end
        end else if (cmd_done_i) begin
            launch = 1'b1;
            case (state_q)
                ST_START:  state_d = ST_DEV_W;
                ST_DEV_W:  state_d = ST_ACK_DW;
                ST_ACK_DW: begin
                    if (slave_ack_i) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        state_d = TWO_BYTE ? ST_REG_H : ST_REG_L;
                    end
                end
                ST_REG_H:  state_d = ST_ACK_RH;
                ST_ACK_RH: begin
                    if (slave_ack_i) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_REG_L;
                    end
                end
                ST_REG_L:  state_d = ST_ACK_RL;
                ST_ACK_RL: begin
                    if (slave_ack_i) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        state_d = rw_q ? ST_RSTART : ST_WDATA;
                    end
                end
                ST_WDATA:  state_d = ST_ACK_WD;
                ST_ACK_WD: begin
                    if (slave_ack_i) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else if (cnt_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        state_d = ST_WDATA;
                    end
                end
                ST_RSTART: state_d = ST_DEV_R;
                ST_DEV_R:  state_d = ST_ACK_DR;
                ST_ACK_DR: begin
                    if (slave_ack_i) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    rd_data_d  = rd_data_i;
                    rd_valid_d = 1'b1;
                    state_d    = ST_MACK;
                end
                ST_MACK: begin
                    if (cnt_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        state_d = ST_RDATA;
                    end
                end
                ST_STOP: begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    cmd_sta_d = CMD_IDLE;
                    launch    = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    launch  = 1'b0;
                end
            endcase
        end

        // The engine latches tx_data at the cmd_done of the command before a WR,
        // so the byte is staged when that preceding command is launched.
        if (launch) begin
            cmd_en_d  = 1'b1;
            cmd_sta_d = state_cmd(state_d);
            case (state_d)
                ST_START:  tx_d = {dev_d, 1'b0};
                ST_ACK_DW: tx_d = TWO_BYTE ? reg_q[15:8] : reg_q[7:0];
                ST_ACK_RH: tx_d = reg_q[7:0];
                ST_ACK_RL: begin
                    if (!rw_q) begin
                        tx_d    = wr_data_i;
                        wr_rd_d = 1'b1;
                    end
                end
                ST_ACK_WD: begin
                    if (cnt_q != 4'd0) begin
                        tx_d    = wr_data_i;
                        wr_rd_d = 1'b1;
                    end
                end
                ST_RSTART: tx_d = {dev_q, 1'b1};
                ST_MACK:   rd_over_d = (cnt_q == 4'd0);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            dev_q      <= 7'd0;
            reg_q      <= 16'd0;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cmd_en_q   <= 1'b0;
            cmd_sta_q  <= CMD_IDLE;
            tx_q       <= 8'd0;
            rd_over_q  <= 1'b1;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            wr_rd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cmd_en_q   <= cmd_en_d;
            cmd_sta_q  <= cmd_sta_d;
            tx_q       <= tx_d;
            rd_over_q  <= rd_over_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_rd_q    <= wr_rd_d;
        end
    end

    assign wr_data_rd_o = wr_rd_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign cmd_en_o     = cmd_en_q;
    assign cmd_sta_o    = cmd_sta_q;
    assign tx_data_o    = tx_q;
    assign rd_over_o    = rd_over_q;

endmodule

// File: tb/tb_mi2c_ctrl.sv
// Bench for mi2c_ctrl: a behavioural engine answers each command, a scoreboard
// queue holds the expected command stream, read bytes and write-byte source.
module tb_mi2c_ctrl;
    import mi2c_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req_rw, sel;
    logic [6:0]  dev;
    logic [15:0] regaddr;
    logic [3:0]  len;
    logic [7:0]  wr_data;
    logic        slave_ack, cmd_done;
    logic [7:0]  rd_data_in;

    logic        a_wr_rd, a_rd_valid, a_busy, a_done, a_err, a_cmd_en, a_rd_over;
    logic [7:0]  a_rd_data, a_tx;
    logic [5:0]  a_cmd_sta;
    logic        b_wr_rd, b_rd_valid, b_busy, b_done, b_err, b_cmd_en, b_rd_over;
    logic [7:0]  b_rd_data, b_tx;
    logic [5:0]  b_cmd_sta;

    logic        m_wr_rd, m_rd_valid, m_busy, m_done, m_err, m_cmd_en, m_rd_over;
    logic [7:0]  m_rd_data, m_tx;
    logic [5:0]  m_cmd_sta;

    always #5 clk = ~clk;

    mi2c_ctrl #(.REG_ADDR_BYTES(1)) u_a (
        .clk_i(clk), .rst_n(rst_n), .req_i(req & ~sel), .req_rw_i(req_rw),
        .dev_addr_i(dev), .reg_addr_i(regaddr), .len_i(len), .wr_data_i(wr_data),
        .wr_data_rd_o(a_wr_rd), .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid),
        .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .cmd_en_o(a_cmd_en),
        .cmd_sta_o(a_cmd_sta), .tx_data_o(a_tx), .rd_over_o(a_rd_over),
        .slave_ack_i(slave_ack), .cmd_done_i(cmd_done), .rd_data_i(rd_data_in)
    );

    mi2c_ctrl #(.REG_ADDR_BYTES(2)) u_b (
        .clk_i(clk), .rst_n(rst_n), .req_i(req & sel), .req_rw_i(req_rw),
        .dev_addr_i(dev), .reg_addr_i(regaddr), .len_i(len), .wr_data_i(wr_data),
        .wr_data_rd_o(b_wr_rd), .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid),
        .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .cmd_en_o(b_cmd_en),
        .cmd_sta_o(b_cmd_sta), .tx_data_o(b_tx), .rd_over_o(b_rd_over),
        .slave_ack_i(slave_ack), .cmd_done_i(cmd_done), .rd_data_i(rd_data_in)
    );

    assign m_wr_rd    = sel ? b_wr_rd    : a_wr_rd;
    assign m_rd_valid = sel ? b_rd_valid : a_rd_valid;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_done     = sel ? b_done     : a_done;
    assign m_err      = sel ? b_err      : a_err;
    assign m_cmd_en   = sel ? b_cmd_en   : a_cmd_en;
    assign m_rd_over  = sel ? b_rd_over  : a_rd_over;
    assign m_rd_data  = sel ? b_rd_data  : a_rd_data;
    assign m_tx       = sel ? b_tx       : a_tx;
    assign m_cmd_sta  = sel ? b_cmd_sta  : a_cmd_sta;

    typedef struct {
        logic [5:0] cmd;
        logic [7:0] tx;
        logic       over;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] wr_src[$];
    logic [7:0] rd_src[$];
    logic [7:0] exp_rd[$];
    int         total = 0;
    int         bad = 0;
    int         wr_pulses = 0;
    int         rd_pulses = 0;
    int         nack_at = -1;
    int         gack_idx = 0;
    logic [7:0] latched_tx = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [5:0] c, input logic [7:0] t, input logic o);
        exp_t e;
        e.cmd = c;
        e.tx = t;
        e.over = o;
        exp_q.push_back(e);
    endtask

    task automatic push_addr(input logic [6:0] d, input logic [15:0] r, input bit two);
        push(CMD_STAR, 8'h00, 1'b0);
        push(CMD_WR, {d, 1'b0}, 1'b0);
        push(CMD_GACK, 8'h00, 1'b0);
        if (two) begin
            push(CMD_WR, r[15:8], 1'b0);
            push(CMD_GACK, 8'h00, 1'b0);
        end
        push(CMD_WR, r[7:0], 1'b0);
        push(CMD_GACK, 8'h00, 1'b0);
    endtask

    task automatic push_write(input logic [6:0] d, input logic [15:0] r, input bit two,
                              input int l, input logic [7:0] first);
        logic [7:0] b;
        push_addr(d, r, two);
        for (int i = 0; i <= l; i++) begin
            b = (i == 0) ? first : 8'($urandom_range(0, 255));
            wr_src.push_back(b);
            push(CMD_WR, b, 1'b0);
            push(CMD_GACK, 8'h00, 1'b0);
        end
        push(CMD_STOP, 8'h00, 1'b0);
    endtask

    task automatic push_read(input logic [6:0] d, input logic [15:0] r, input bit two,
                             input int l, input logic [7:0] base);
        logic [7:0] b;
        push_addr(d, r, two);
        push(CMD_STAR, 8'h00, 1'b0);
        push(CMD_WR, {d, 1'b1}, 1'b0);
        push(CMD_GACK, 8'h00, 1'b0);
        for (int i = 0; i <= l; i++) begin
            b = base + 8'(i * 8'h11);
            rd_src.push_back(b);
            exp_rd.push_back(b);
            push(CMD_RD, 8'h00, 1'b0);
            push(CMD_OACK, 8'h00, (i == l));
        end
        push(CMD_STOP, 8'h00, 1'b0);
    endtask

    task automatic issue(input logic rw, input logic [6:0] d, input logic [15:0] r, input logic [3:0] l);
        @(negedge clk);
        req_rw = rw; dev = d; regaddr = r; len = l; gack_idx = 0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic got_err);
        int n = 0;
        while (m_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(m_done === 1'b1), 32'd1);
        got_err = m_err;
    endtask

    // Behavioural engine: checks each launched command, then answers with cmd_done.
    initial begin : engine
        exp_t       e;
        logic [5:0] c;
        logic       ab;
        cmd_done = 1'b0;
        slave_ack = 1'b0;
        rd_data_in = 8'h00;
        forever begin
            @(posedge clk); #1;
            while (m_cmd_en === 1'b1) begin
                c = m_cmd_sta;
                chk("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("cmd", {26'd0, c}, {26'd0, e.cmd});
                    if (e.cmd == CMD_WR) chk("tx_at_prev_done", {24'd0, latched_tx}, {24'd0, e.tx});
                    if (e.cmd == CMD_OACK) chk("rd_over", {31'd0, m_rd_over}, {31'd0, e.over});
                end
                ab = 1'b0;
                @(posedge clk); #1;
                if (rst_n !== 1'b1) ab = 1'b1;
                else chk("en_one_cycle", {31'd0, m_cmd_en}, 32'd0);
                if (ab) break;
                @(posedge clk); #1;
                if (rst_n !== 1'b1) break;
                chk("sta_held", {26'd0, m_cmd_sta}, {26'd0, c});
                slave_ack = (c == CMD_GACK) && (gack_idx == nack_at);
                if (c == CMD_GACK) gack_idx++;
                if (c == CMD_RD && rd_src.size() != 0) rd_data_in = rd_src.pop_front();
                latched_tx = m_tx;
                cmd_done = 1'b1;
                @(posedge clk); #1;
                cmd_done = 1'b0;
                slave_ack = 1'b0;
            end
        end
    end

    // Output monitor: FWFT write-byte source and read-byte scoreboard.
    initial begin : monitor
        wr_data = 8'h00;
        forever begin
            @(negedge clk);
            if (m_wr_rd === 1'b1) begin
                wr_pulses++;
                if (wr_src.size() != 0) void'(wr_src.pop_front());
            end
            if (m_rd_valid === 1'b1) begin
                rd_pulses++;
                chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) chk("rd_data", {24'd0, m_rd_data}, {24'd0, exp_rd.pop_front()});
            end
            wr_data = (wr_src.size() != 0) ? wr_src[0] : 8'h00;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic e;
        int   n;
        sel = 1'b0; req = 1'b0; req_rw = 1'b0; dev = 7'd0; regaddr = 16'd0; len = 4'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_cmd_sta", {26'd0, m_cmd_sta}, {26'd0, CMD_IDLE});
            chk("rst_tx", {24'd0, m_tx}, 32'd0);
            chk("rst_rd_over", {31'd0, m_rd_over}, 32'd1);
            chk("rst_rd_data", {24'd0, m_rd_data}, 32'd0);
            chk("rst_flags", {26'd0, m_err, m_busy, m_done, m_cmd_en, m_wr_rd, m_rd_valid}, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-byte write, 1-byte register address
        push_write(7'h50, 16'h0012, 1'b0, 0, 8'hA5);
        wr_pulses = 0;
        @(negedge clk);
        req_rw = 1'b0; dev = 7'h50; regaddr = 16'h0012; len = 4'd0; gack_idx = 0; req = 1'b1;
        @(posedge clk); #2;
        chk("accept_busy", {31'd0, m_busy}, 32'd1);
        chk("accept_en", {31'd0, m_cmd_en}, 32'd1);
        chk("accept_sta", {26'd0, m_cmd_sta}, {26'd0, CMD_STAR});
        chk("accept_tx", {24'd0, m_tx}, 32'hA0);
        req = 1'b0;
        wait_done(1000, e);
        chk("w1_err", {31'd0, e}, 32'd0);
        chk("w1_busy_at_done", {31'd0, m_busy}, 32'd0);
        @(negedge clk);
        chk("w1_wr_pulses", wr_pulses, 32'd1);
        chk("w1_sb_empty", exp_q.size(), 32'd0);

        // Two-byte register address read, three bytes
        sel = 1'b1;
        push_read(7'h68, 16'h0304, 1'b1, 2, 8'h11);
        rd_pulses = 0;
        issue(1'b1, 7'h68, 16'h0304, 4'd2);
        wait_done(1000, e);
        chk("r1_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        chk("r1_rd_pulses", rd_pulses, 32'd3);
        chk("r1_sb_empty", exp_q.size(), 32'd0);
        chk("r1_rd_drained", exp_rd.size(), 32'd0);

        // Address NACK
        sel = 1'b0;
        push(CMD_STAR, 8'h00, 1'b0);
        push(CMD_WR, 8'h78, 1'b0);
        push(CMD_GACK, 8'h00, 1'b0);
        push(CMD_STOP, 8'h00, 1'b0);
        wr_pulses = 0;
        nack_at = 0;
        issue(1'b0, 7'h3C, 16'h0040, 4'd3);
        wait_done(1000, e);
        chk("nack_err", {31'd0, e}, 32'd1);
        repeat (3) @(negedge clk);
        chk("nack_err_held", {31'd0, m_err}, 32'd1);
        chk("nack_wr_pulses", wr_pulses, 32'd0);
        chk("nack_sb_empty", exp_q.size(), 32'd0);
        nack_at = -1;

        // 16-byte write burst
        push_write(7'h50, 16'h0080, 1'b0, 15, 8'h3C);
        wr_pulses = 0;
        issue(1'b0, 7'h50, 16'h0080, 4'd15);
        wait_done(2000, e);
        chk("burst_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        chk("burst_wr_pulses", wr_pulses, 32'd16);
        chk("burst_src_drained", wr_src.size(), 32'd0);
        chk("burst_sb_empty", exp_q.size(), 32'd0);

        // req held high across a transaction
        push_write(7'h21, 16'h0001, 1'b0, 0, 8'h5A);
        push_write(7'h21, 16'h0001, 1'b0, 0, 8'h6B);
        wr_pulses = 0;
        @(negedge clk);
        req_rw = 1'b0; dev = 7'h21; regaddr = 16'h0001; len = 4'd0; gack_idx = 0; req = 1'b1;
        wait_done(1000, e);
        chk("held_busy_done_cycle", {31'd0, m_busy}, 32'd0);
        @(negedge clk);
        chk("held_not_on_done", {31'd0, m_busy}, 32'd0);
        @(negedge clk);
        chk("held_second_accept", {31'd0, m_busy}, 32'd1);
        req = 1'b0;
        gack_idx = 0;
        wait_done(1000, e);
        chk("held_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        chk("held_wr_pulses", wr_pulses, 32'd2);
        chk("held_sb_empty", exp_q.size(), 32'd0);

        // Reset during the second RDATA
        sel = 1'b1;
        push_read(7'h68, 16'h0010, 1'b1, 1, 8'h44);
        rd_pulses = 0;
        issue(1'b1, 7'h68, 16'h0010, 4'd1);
        n = 0;
        while (m_cmd_sta !== CMD_OACK && n < 400) begin @(negedge clk); n++; end
        while (m_cmd_sta !== CMD_RD && n < 400) begin @(negedge clk); n++; end
        chk("rst_reach_rdata", {26'd0, m_cmd_sta}, {26'd0, CMD_RD});
        chk("rst_over_before", {31'd0, m_rd_over}, 32'd0);
        chk("rst_first_byte", rd_pulses, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cmd_sta", {26'd0, m_cmd_sta}, {26'd0, CMD_IDLE});
        chk("arst_tx", {24'd0, m_tx}, 32'd0);
        chk("arst_rd_over", {31'd0, m_rd_over}, 32'd1);
        chk("arst_rd_data", {24'd0, m_rd_data}, 32'd0);
        chk("arst_flags", {26'd0, m_err, m_busy, m_done, m_cmd_en, m_wr_rd, m_rd_valid}, 32'd0);
        exp_q.delete();
        rd_src.delete();
        exp_rd.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        push_read(7'h68, 16'h0304, 1'b1, 0, 8'h77);
        rd_pulses = 0;
        issue(1'b1, 7'h68, 16'h0304, 4'd0);
        wait_done(1000, e);
        chk("post_rst_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        chk("post_rst_rd_pulses", rd_pulses, 32'd1);
        chk("post_rst_sb_empty", exp_q.size(), 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
